// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient loader: register map, control bits,
// AXI response codes, loader state encoding and small helpers.
package biquad_pkg;

    // Register offsets within one biquad block
    localparam logic [7:0] REG_CTRL = 8'h00;
    localparam logic [7:0] REG_B0   = 8'h04;
    localparam logic [7:0] REG_B1   = 8'h08;
    localparam logic [7:0] REG_B2   = 8'h0C;
    localparam logic [7:0] REG_A1   = 8'h10;
    localparam logic [7:0] REG_A2   = 8'h14;

    // CTRL register bit positions
    localparam int unsigned CTRL_ENABLE     = 0;
    localparam int unsigned CTRL_SOFT_RESET = 1;

    localparam logic [31:0] CTRL_WORD_RESET = (32'd1 << CTRL_ENABLE) | (32'd1 << CTRL_SOFT_RESET);
    localparam logic [31:0] CTRL_WORD_RUN   = (32'd1 << CTRL_ENABLE);

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned NUM_COEFS  = 5;
    localparam int unsigned NUM_WRITES = 7;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } loader_state_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Offset of coefficient k (0 = b0 .. 4 = a2)
    function automatic logic [7:0] coef_offset(input logic [2:0] k);
        return REG_B0 + {3'b000, k, 2'b00};
    endfunction

endpackage

// File: rtl/axil_master_write_single.sv
// Single AXI4-Lite write transaction: AW and W are tracked independently, B is accepted
// once both have handshaken.
module axil_master_write_single
    import biquad_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    req,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    addr_data_done,
    output logic                    resp_fire,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_fire, w_fire;

    assign aw_fire = awvalid_q & m_axi_awready;
    assign w_fire  = wvalid_q & m_axi_wready;

    // Both channels finish this cycle: nothing left pending after the current handshakes
    assign addr_data_done = (awvalid_q | wvalid_q) & ~(awvalid_q & ~aw_fire) &
                            ~(wvalid_q & ~w_fire);
    assign resp_fire      = bready_q & m_axi_bvalid;
    assign resp_err       = resp_fire & (m_axi_bresp != AXI_RESP_OKAY);

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

    // Next-state of the channel valids/ready and the held address/data
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        if (req) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr;
            wdata_d   = data;
        end else begin
            if (aw_fire) awvalid_d = 1'b0;
            if (w_fire)  wvalid_d  = 1'b0;
        end
        if (addr_data_done) bready_d = 1'b1;
        if (resp_fire)      bready_d = 1'b0;
    end

    // Channel state registers, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

endmodule

// File: rtl/biquad_coef_loader.sv
// AXI4-Lite master that programs a biquad block: CTRL=0x3, b0, b1, b2, a1, a2, CTRL=0x1.
// Optional readback verification of the coefficients is built when BQ_LOADER_READBACK_EN
// is defined.
module biquad_coef_loader
    import biquad_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [15:0]             coef_b0,
    input  logic [15:0]             coef_b1,
    input  logic [15:0]             coef_b2,
    input  logic [15:0]             coef_a1,
    input  logic [15:0]             coef_a2,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    loader_state_e                  state_q, state_d;
    logic [2:0]                     wr_idx_q, wr_idx_d;
    logic                           err_q, err_d;
    logic [NUM_COEFS-1:0][15:0]     shadow_q, shadow_d;

    logic                           wr_req;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           wr_addr_data_done;
    logic                           wr_resp_fire;
    logic                           wr_resp_err;
    logic                           unused_rd;

`ifdef BQ_LOADER_READBACK_EN
    logic [2:0]                     rd_idx_q, rd_idx_d;
    logic [ADDR_WIDTH-1:0]          araddr_q, araddr_d;
`endif

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [7:0] off);
        return ADDR_WIDTH'(BASE_ADDR + 32'(off));
    endfunction

    assign busy = (state_q != StIdle) && (state_q != StDone);
    assign done = (state_q == StDone);
    assign err  = err_q;

    // Loader sequencing: next state, write index, error flag, shadow capture
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        wr_req   = 1'b0;
`ifdef BQ_LOADER_READBACK_EN
        rd_idx_d = rd_idx_q;
        araddr_d = araddr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = {coef_a2, coef_a1, coef_b2, coef_b1, coef_b0};
                    err_d    = 1'b0;
                    wr_idx_d = 3'd0;
                    wr_req   = 1'b1;
                    state_d  = StWrAddrData;
                end
            end
            StWrAddrData: begin
                if (wr_addr_data_done) state_d = StWrResp;
            end
            StWrResp: begin
                if (wr_resp_fire) begin
                    if (wr_resp_err) err_d = 1'b1;
                    // Errors never cut the sequence short so the final CTRL write always lands
                    if (wr_idx_q < 3'(NUM_WRITES - 1)) begin
                        wr_idx_d = wr_idx_q + 3'd1;
                        wr_req   = 1'b1;
                        state_d  = StWrAddrData;
                    end else begin
`ifdef BQ_LOADER_READBACK_EN
                        rd_idx_d = 3'd0;
                        araddr_d = reg_addr(coef_offset(3'd0));
                        state_d  = StRdAddr;
`else
                        state_d  = StDone;
`endif
                    end
                end
            end
`ifdef BQ_LOADER_READBACK_EN
            StRdAddr: begin
                if (m_axi_arready) state_d = StRdData;
            end
            StRdData: begin
                if (m_axi_rvalid) begin
                    if ((m_axi_rdata[15:0] != shadow_q[rd_idx_q]) ||
                        (m_axi_rresp != AXI_RESP_OKAY)) begin
                        err_d = 1'b1;
                    end
                    if (rd_idx_q == 3'(NUM_COEFS - 1)) begin
                        state_d = StDone;
                    end else begin
                        rd_idx_d = rd_idx_q + 3'd1;
                        araddr_d = reg_addr(coef_offset(rd_idx_q + 3'd1));
                        state_d  = StRdAddr;
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address/data of the write being launched, from the index it will carry
    always_comb begin
        wr_addr = reg_addr(REG_CTRL);
        wr_data = DATA_WIDTH'(CTRL_WORD_RUN);
        if (wr_idx_d == 3'd0) begin
            wr_data = DATA_WIDTH'(CTRL_WORD_RESET);
        end else if (wr_idx_d != 3'(NUM_WRITES - 1)) begin
            wr_addr = reg_addr(coef_offset(wr_idx_d - 3'd1));
            wr_data = DATA_WIDTH'(sext16(shadow_d[wr_idx_d - 3'd1]));
        end
    end

    // Loader state registers, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            wr_idx_q <= 3'd0;
            err_q    <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef BQ_LOADER_READBACK_EN
    // Readback index and address registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_idx_q <= 3'd0;
            araddr_q <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            araddr_q <= araddr_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = (state_q == StRdAddr);
    assign m_axi_rready  = (state_q == StRdData);
    assign unused_rd     = ^m_axi_rdata[DATA_WIDTH-1:16];
`else
    assign m_axi_araddr  = '0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;
    assign unused_rd     = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

    axil_master_write_single #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .req           (wr_req),
        .addr          (wr_addr),
        .data          (wr_data),
        .addr_data_done(wr_addr_data_done),
        .resp_fire     (wr_resp_fire),
        .resp_err      (wr_resp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

endmodule
